// File: rtl/rf_pkg.sv
// Shared widths and the write-request record used by the write-back arbiter.
package rf_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One holding slot of the write-back arbiter: a valid bit plus the held request.
// A load takes priority over a clear so a drained slot can be refilled in the same cycle.
module rf_wb_slot
  import rf_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    load_i,
  input  logic    clear_i,
  input  wb_req_t req_i,
  output logic    valid_o,
  output wb_req_t req_o
);

  logic    valid_d, valid_q;
  wb_req_t req_d, req_q;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (load_i) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file write-back arbiter with oldest-first grant and read hazard flag.
// Optional RF_WB_R0_ZERO_EN: writes to register 0 are accepted but discarded.
module rf_wb_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_val,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard,
  output logic              busy
);

  import rf_pkg::*;

  wb_req_t req0_in, req1_in;
  wb_req_t slot0_req, slot1_req;
  logic    slot0_valid, slot1_valid;
  logic    grant0, grant1;
  logic    accept0, accept1;
  logic    load0, load1;
  // Set when slot 1 holds the older write.
  logic    older_d, older_q;

  assign req0_in.addr = req0_addr;
  assign req0_in.data = req0_data;
  assign req1_in.addr = req1_addr;
  assign req1_in.data = req1_data;

  assign grant0 = slot0_valid && (!slot1_valid || !older_q);
  assign grant1 = slot1_valid && (!slot0_valid || older_q);

  assign req0_ready = !slot0_valid || grant0;
  assign req1_ready = !slot1_valid || grant1;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

`ifdef RF_WB_R0_ZERO_EN
  assign load0 = accept0 && (req0_addr != '0);
  assign load1 = accept1 && (req1_addr != '0);
`else
  assign load0 = accept0;
  assign load1 = accept1;
`endif

  // Simultaneous loads order slot 0 first so slot 1's value lands last.
  always_comb begin
    older_d = older_q;
    if (load0 && load1) begin
      older_d = 1'b0;
    end else if (load0) begin
      older_d = 1'b1;
    end else if (load1) begin
      older_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_q <= 1'b0;
    end else begin
      older_q <= older_d;
    end
  end

  rf_wb_slot u_slot0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (load0),
    .clear_i (grant0),
    .req_i   (req0_in),
    .valid_o (slot0_valid),
    .req_o   (slot0_req)
  );

  rf_wb_slot u_slot1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (load1),
    .clear_i (grant1),
    .req_i   (req1_in),
    .valid_o (slot1_valid),
    .req_o   (slot1_req)
  );

  always_comb begin
    rf_wr_en      = grant0 || grant1;
    rf_write_addr = '0;
    rf_write_val  = '0;
    if (grant0) begin
      rf_write_addr = slot0_req.addr;
      rf_write_val  = slot0_req.data;
    end else if (grant1) begin
      rf_write_addr = slot1_req.addr;
      rf_write_val  = slot1_req.data;
    end
  end

  // The granted slot still counts: its write is not visible to readers until the next edge.
  assign hazard = (slot0_valid && ((slot0_req.addr == chk_addr1) ||
                                   (slot0_req.addr == chk_addr2))) ||
                  (slot1_valid && ((slot1_req.addr == chk_addr1) ||
                                   (slot1_req.addr == chk_addr2)));

  assign busy = slot0_valid || slot1_valid;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: ADDR_W, 3, register-file address width (8 registers).
REQ-002 Parameter: DATA_W, 8, register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 has a write pending.
REQ-006 req0_addr / req1_addr  input  ADDR_W  destination register of requester 0/1.
REQ-007 req0_data / req1_data  input  DATA_W  write data of requester 0/1.
REQ-008 req0_ready / req1_ready  output  1  slot of requester 0/1 can accept this cycle.
REQ-009 rf_wr_en  output  1  write enable to register file.
REQ-010 rf_write_addr  output  ADDR_W  write address to register file.
REQ-011 rf_write_val  output  DATA_W  write data to register file.
REQ-012 chk_addr1 / chk_addr2  input  ADDR_W  read addresses the decode stage is about to use.
REQ-013 hazard  output  1  a held write targets chk_addr1 or chk_addr2.
REQ-014 busy  output  1  at least one slot holds a write.

Function
REQ-015 Each requester SHALL own one holding slot (valid, addr, data, age); handshake completes when valid and ready are both high at a posedge.
REQ-016 reqN_ready SHALL equal !slotN_valid || grantN (accept and drain in the same cycle permitted).
REQ-017 Only registered slot state SHALL drive rf_wr_en/addr/val; rf_wr_en = grant0 || grant1.
REQ-018 Latency: request accepted at edge N SHALL present rf_wr_en in cycle N+1, committed to the register file at edge N+2 if granted.
REQ-019 One slot valid: that slot SHALL be granted.
REQ-020 Both valid: the slot accepted earlier SHALL be granted; same accept edge: slot 0 first, then slot 1 (slot 1 value survives on equal addresses).
REQ-021 Age SHALL be tracked by a single bit "older", updated on each accept; a slot waits at most one cycle.
REQ-022 Granted slot SHALL clear at the next edge unless refilled by a same-cycle handshake.
REQ-023 hazard SHALL be combinational: any valid slot whose addr equals chk_addr1 or chk_addr2 (granted slot included, since its write is not yet visible).
REQ-024 busy = slot0_valid || slot1_valid.
REQ-025 When rf_wr_en is low, rf_write_addr and rf_write_val SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately clear both slots, the age bit, and force rf_wr_en, hazard, busy to 0 and both readys to 1.
REQ-027 Reset mid-operation SHALL drop held writes; no partial write issued after reset release.
REQ-028 First accept is possible on the first posedge with rst_n high.

Configuration
REQ-029 Macro RF_WB_R0_ZERO_EN defined: requests with addr 0 SHALL be accepted (ready honoured) but never placed in a slot and never produce rf_wr_en or hazard.
REQ-030 RF_WB_R0_ZERO_EN undefined: register 0 SHALL be treated like any other register.

Structure
REQ-031 Package rf_pkg SHALL hold ADDR_W, DATA_W, NUM_REGS=8, and typedef wb_req_t {addr, data}.
REQ-032 Sub-module rf_wb_slot (one holding slot: valid, wb_req_t, load/clear) SHALL be instantiated twice.
REQ-033 Implementation SHALL be 120-400 lines total.

Verification
REQ-034 req0 addr=3 data=0x5A at edge 1, req1 idle -> rf_wr_en=1, addr=3, val=0x5A in cycle 2 only; busy low after edge 2.
REQ-035 req0 (addr=2,0x11) and req1 (addr=2,0x22) same edge -> cycle 2 writes 0x11, cycle 3 writes 0x22; req1_ready=0 in cycle 2.
REQ-036 req1 (4,0x33) at edge 1, req0 (5,0x44) at edge 2 -> cycle 2 writes r4, cycle 3 writes r5 (oldest first).
REQ-037 Slot0 holds addr=6, chk_addr1=6 -> hazard=1; chk_addr1=chk_addr2=1 -> hazard=0.
REQ-038 Both slots valid, rst_n pulsed low mid-cycle -> rf_wr_en, busy drop at once; no write after release.
REQ-039 RF_WB_R0_ZERO_EN defined, req0 addr=0 data=0xFF -> ready=1, no rf_wr_en, hazard=0 for chk_addr1=0.
